// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants for the register-file writeback arbiter.
// Imported by the interface, arbiter and top.
package regfile_wb_arbiter_pkg;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  localparam int NUM_WB_REQ = 3;
  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request bundle: per-source valid/addr/data
// with a one-hot ready returned by the arbiter.
interface regfile_wb_arbiter_if
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int NUM_REQ = NUM_WB_REQ,
  parameter int ADDR_W  = REG_ADDR_W,
  parameter int DATA_W  = REG_DATA_W
);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;

  modport master (
    output req_valid,
    output req_addr,
    output req_data,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    input  req_data,
    output req_ready
  );

endinterface

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: searches upward from ptr,
// wrapping, and grants the first active request.
module rr_arbiter #(
  parameter  int NUM_REQ = 3,
  localparam int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [PTR_W-1:0]   grant_idx,
  output logic               grant_valid
);

  int j;

  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    j           = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!grant_valid && req[PTR_W'(j)]) begin
        grant_valid         = 1'b1;
        grant[PTR_W'(j)]    = 1'b1;
        grant_idx           = PTR_W'(j);
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the regfile write port between writeback sources and
// tracks outstanding destination writes for RAW hazard checks.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter  int NUM_REQ = NUM_WB_REQ,
  parameter  int ADDR_W  = REG_ADDR_W,
  parameter  int DATA_W  = REG_DATA_W,
  localparam int PTR_W   = $clog2(NUM_REQ),
  localparam int BUSY_W  = 1 << ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  regfile_wb_arbiter_if.slave wb,
  input  logic              rsv_valid,
  input  logic [ADDR_W-1:0] rsv_addr,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] data_in,
  output logic              write_enable,
  output logic [BUSY_W-1:0] busy
);

  localparam logic [ADDR_W-1:0] X0 = ADDR_W'(REG_ZERO);

  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   g_idx;
  logic [NUM_REQ-1:0] grant;
  logic               g_vld;
  logic               hs;
  logic [ADDR_W-1:0]  g_addr;
  logic [DATA_W-1:0]  g_data;
  logic [BUSY_W-1:0]  busy_nxt;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req         (wb.req_valid),
    .ptr         (rr_ptr),
    .grant       (grant),
    .grant_idx   (g_idx),
    .grant_valid (g_vld)
  );

  assign wb.req_ready = rst ? '0 : grant;
  assign hs           = g_vld & ~rst;
  assign g_addr       = wb.req_addr[int'(g_idx)*ADDR_W +: ADDR_W];
  assign g_data       = wb.req_data[int'(g_idx)*DATA_W +: DATA_W];

  // Set is applied after clear so a new producer wins the same-cycle race.
  always_comb begin
    busy_nxt = busy;
    if (hs && g_addr != X0)
      busy_nxt[g_addr] = 1'b0;
    if (rsv_valid && rsv_addr != X0)
      busy_nxt[rsv_addr] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr       <= '0;
      wr_addr      <= '0;
      data_in      <= '0;
      write_enable <= DISABLE;
      busy         <= '0;
    end else begin
      busy <= busy_nxt;
      if (hs) begin
        wr_addr      <= g_addr;
        data_in      <= g_data;
        write_enable <= (g_addr != X0) ? ENABLE : DISABLE;
        rr_ptr       <= (g_idx == PTR_W'(NUM_REQ-1))
                        ? '0 : g_idx + 1'b1;
      end else begin
        write_enable <= DISABLE;
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed cases with literal
// expectations, then random traffic against a behavioural model.
module tb_regfile_wb_arbiter;
  import regfile_wb_arbiter_pkg::*;

  localparam int N  = 3;
  localparam int AW = 5;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  regfile_wb_arbiter_if #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) wb();

  logic [N-1:0]  v = '0;
  logic [AW-1:0] a [N];
  logic [DW-1:0] d [N];
  logic          rsv_valid = 1'b0;
  logic [AW-1:0] rsv_addr = '0;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] data_in;
  logic          write_enable;
  logic [31:0]   busy;

  assign wb.req_valid = v;
  for (genvar i = 0; i < N; i++) begin : g_pack
    assign wb.req_addr[i*AW +: AW] = a[i];
    assign wb.req_data[i*DW +: DW] = d[i];
  end

  regfile_wb_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk          (clk),
    .rst          (rst),
    .wb           (wb),
    .rsv_valid    (rsv_valid),
    .rsv_addr     (rsv_addr),
    .wr_addr      (wr_addr),
    .data_in      (data_in),
    .write_enable (write_enable),
    .busy         (busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Behavioural model: state as it will be after the next rising edge.
  int          m_ptr  = 0;
  bit          m_we   = 0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_data = '0;
  bit [31:0]   m_busy = '0;
  int          hs_idx = -1;

  always @(negedge clk) begin
    int g;
    int idx;
    logic [N-1:0] er;
    g  = -1;
    er = '0;
    if (!rst) begin
      for (int k = 0; k < N; k++) begin
        idx = (m_ptr + k) % N;
        if (g < 0 && v[idx]) g = idx;
      end
    end
    if (g >= 0) er[g] = 1'b1;
    chk("req_ready", 64'(wb.req_ready), 64'(er));
    chk("write_enable", 64'(write_enable), 64'(m_we));
    if (m_we) begin
      chk("wr_addr", 64'(wr_addr), 64'(m_addr));
      chk("data_in", 64'(data_in), 64'(m_data));
    end
    chk("busy", 64'(busy), 64'(m_busy));
    if (rst) begin
      m_ptr = 0; m_we = 0; m_addr = '0; m_data = '0; m_busy = '0;
    end else begin
      m_we = 0;
      if (g >= 0) begin
        m_addr = a[g];
        m_data = d[g];
        m_we   = (a[g] != 0);
        m_ptr  = (g + 1) % N;
        m_busy[a[g]] = 1'b0;
      end
      if (rsv_valid) m_busy[rsv_addr] = 1'b1;
      m_busy[0] = 1'b0;
    end
    hs_idx = g;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      a[i] = AW'(i + 1);
      d[i] = 32'hA000_0000 + 32'(i);
    end
    v = 3'b111;
    settle();
    chk("rst_ready", 64'(wb.req_ready), 64'h0);
    chk("rst_we", 64'(write_enable), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    cyc(); rst = 1'b0;
    settle(); chk("rr_g0", 64'(wb.req_ready), 64'b001);
    cyc(); settle();
    chk("rr_g1", 64'(wb.req_ready), 64'b010);
    chk("rr_we1", 64'(write_enable), 64'h1);
    chk("rr_wa1", 64'(wr_addr), 64'd1);
    chk("rr_wd1", 64'(data_in), 64'hA000_0000);
    cyc(); settle();
    chk("rr_g2", 64'(wb.req_ready), 64'b100);
    chk("rr_wa2", 64'(wr_addr), 64'd2);
    cyc(); settle();
    chk("rr_g3", 64'(wb.req_ready), 64'b001);
    chk("rr_wa3", 64'(wr_addr), 64'd3);
    cyc(); v = '0; settle();
    chk("idle_ready", 64'(wb.req_ready), 64'h0);
    chk("last_wa", 64'(wr_addr), 64'd1);
    cyc(); v = 3'b100; a[2] = 5'd7; d[2] = 32'hDEADBEEF; settle();
    chk("idle_we", 64'(write_enable), 64'h0);
    chk("solo2_ready", 64'(wb.req_ready), 64'b100);
    cyc(); v = '0; settle();
    chk("solo2_we", 64'(write_enable), 64'h1);
    chk("solo2_wa", 64'(wr_addr), 64'd7);
    chk("solo2_wd", 64'(data_in), 64'hDEADBEEF);
    cyc(); v = 3'b011; rsv_valid = 1'b1; rsv_addr = 5'd5; settle();
    chk("ptr_wrap", 64'(wb.req_ready), 64'b001);
    cyc(); v = '0; rsv_valid = 1'b0; settle();
    chk("rsv_set", 64'(busy), 64'h20);
    cyc(); v = 3'b001; a[0] = 5'd5; settle();
    chk("busy_hold", 64'(busy), 64'h20);
    cyc(); v = '0; settle();
    chk("busy_clr", 64'(busy), 64'h0);
    chk("busy_clr_wa", 64'(wr_addr), 64'd5);
    cyc(); v = 3'b001; rsv_valid = 1'b1; settle();
    cyc(); v = '0; rsv_valid = 1'b0; settle();
    chk("set_wins", 64'(busy), 64'h20);
    cyc(); v = 3'b010; a[1] = 5'd0; d[1] = 32'h1234;
    rsv_valid = 1'b1; rsv_addr = 5'd0; settle();
    chk("x0_ready", 64'(wb.req_ready), 64'b010);
    cyc(); v = '0; rsv_valid = 1'b0; settle();
    chk("x0_we", 64'(write_enable), 64'h0);
    chk("x0_busy", 64'(busy), 64'h20);
    cyc(); v = 3'b010; a[1] = 5'd9; settle();
    chk("pre_rst_ready", 64'(wb.req_ready), 64'b010);
    cyc(); v = '0; rst = 1'b1; settle();
    chk("mid_rst_we", 64'(write_enable), 64'h1);
    chk("mid_rst_wa", 64'(wr_addr), 64'd9);
    cyc(); rst = 1'b0; v = 3'b111;
    for (int i = 0; i < N; i++) a[i] = AW'(i + 1);
    settle();
    chk("post_rst_we", 64'(write_enable), 64'h0);
    chk("post_rst_busy", 64'(busy), 64'h0);
    chk("post_rst_ready", 64'(wb.req_ready), 64'b001);
    cyc(); v = '0;

    for (int c = 0; c < 3000; c++) begin
      cyc();
      if (hs_idx >= 0) v[hs_idx] = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (!v[i] && ($urandom % 2 == 0)) begin
          v[i] = 1'b1;
          a[i] = AW'($urandom_range(0, 7));
          d[i] = $urandom;
        end
      end
      rsv_valid = ($urandom % 3 == 0);
      rsv_addr  = AW'($urandom_range(0, 7));
      rst       = ($urandom % 150 == 0);
    end
    cyc(); rst = 1'b0; v = '0; rsv_valid = 1'b0;
    cyc(); cyc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
